// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per block.
// Hits are returned combinationally in the lookup cycle. A miss starts a
// single outstanding fill, and fetch is stalled until that fill lands.
// Hit and miss counters wrap naturally at 2^32.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX   = $clog2(SETS),
    parameter int TAG_W = 30 - IDX
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           r_state;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];
    logic [TAG_W-1:0] r_miss_tag;
    logic [IDX-1:0]   r_miss_idx;
    logic [31:0]      r_hit_count;
    logic [31:0]      r_miss_count;

    logic [TAG_W-1:0] w_tag;
    logic [IDX-1:0]   w_idx;
    logic             w_match;
    logic             w_unused_offset;

    // Address split; the byte offset plays no part in the lookup.
    assign w_tag           = imemaddr[31:IDX+2];
    assign w_idx           = imemaddr[IDX+1:2];
    assign w_unused_offset = ^imemaddr[1:0];

    // Lookups only happen in IDLE, so ihit is forced low for the whole fill.
    assign w_match  = (r_state == IDLE) && imemREN && r_valid[w_idx]
                      && (r_tag[w_idx] == w_tag);
    assign ihit     = w_match;
    assign imemload = w_match ? r_data[w_idx] : 32'h0;

    // The fill request is decoded straight from the state register so that
    // an async reset drops it immediately.
    assign iREN  = (r_state == FILL);
    assign iaddr = (r_state == FILL) ? {r_miss_tag, r_miss_idx, 2'b00} : 32'h0;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Lookup/fill FSM together with the tag store, data store and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_match) begin
                        r_hit_count <= r_hit_count + 32'd1;
                    end else if (imemREN) begin
                        r_miss_tag   <= w_tag;
                        r_miss_idx   <= w_idx;
                        r_miss_count <= r_miss_count + 32'd1;
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    // The fill finishes regardless of what fetch does meanwhile;
                    // the previous occupant of the set is simply replaced.
                    if (!iwait) begin
                        r_valid[r_miss_idx] <= 1'b1;
                        r_tag[r_miss_idx]   <= r_miss_tag;
                        r_data[r_miss_idx]  <= iload;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected hits and fills into
// queues, a monitor checks every hit the cache presents, and a memory
// responder checks every fill address it is asked for.
module tb_icache;

    localparam int SETS = 16;
    localparam int IDX  = 4;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.SETS(SETS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        hit_q[$];
    logic [31:0] fill_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one valid/tag/data entry per set, plus counters.
    bit          m_valid[SETS];
    logic [31:0] m_tag[SETS];
    logic [31:0] m_data[SETS];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic [31:0] mem_ver;
    int          mem_delay;
    int          ren_cycles;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ver == 32'd0 && a == 32'h0000_0040) return 32'h2001_0005;
        return (a * 32'h9E37_79B1) ^ (mem_ver * 32'h85EB_CA6B) ^ 32'h1234_5678;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + IDX);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_data[i]  = 32'h0;
        end
        m_hits   = 32'h0;
        m_misses = 32'h0;
    endtask

    // Records a predicted miss: the fill address and the data it brings in.
    task automatic model_miss(input logic [31:0] addr, output logic [31:0] d);
        logic [31:0] al;
        int          i;
        al = addr & 32'hFFFF_FFFC;
        i  = idx_of(addr);
        d  = mem_word(al);
        m_misses++;
        fill_q.push_back(al);
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(addr);
        m_data[i]  = d;
    endtask

    // Monitor: checks outputs every cycle and pops the scoreboard on each hit.
    initial begin
        exp_t e;
        ren_cycles = 0;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (iREN) begin
                    ren_cycles++;
                    chk(ihit == 1'b0, "fill_no_hit", 32'(ihit), 32'd0);
                end else begin
                    chk(iaddr == 32'h0, "idle_iaddr_zero", iaddr, 32'h0);
                end
                if (ihit) begin
                    if (hit_q.size() == 0) begin
                        chk(1'b0, "unexpected_hit", imemaddr, 32'h0);
                    end else begin
                        e = hit_q.pop_front();
                        chk(imemaddr == e.addr, "hit_addr", imemaddr, e.addr);
                        chk(imemload == e.data, "hit_data", imemload, e.data);
                    end
                end else begin
                    chk(imemload == 32'h0, "miss_load_zero", imemload, 32'h0);
                end
            end
        end
    end

    // Memory responder: holds iwait high for mem_delay cycles of each fill,
    // then returns the memory word for the requested address.
    initial begin
        bit          in_fill;
        int          left;
        logic [31:0] a;
        in_fill = 1'b0;
        left    = 0;
        iwait   = 1'b1;
        iload   = 32'h0;
        forever begin
            @(negedge CLK);
            if (iREN) begin
                if (!in_fill) begin
                    in_fill = 1'b1;
                    left    = mem_delay;
                    if (fill_q.size() == 0) begin
                        chk(1'b0, "unexpected_fill", iaddr, 32'h0);
                    end else begin
                        a = fill_q.pop_front();
                        chk(iaddr == a, "fill_addr", iaddr, a);
                    end
                end
                if (left > 0) begin
                    iwait = 1'b1;
                    iload = $urandom;
                    left--;
                end else begin
                    iwait = 1'b0;
                    iload = mem_word(iaddr);
                end
            end else begin
                in_fill = 1'b0;
                iwait   = 1'b1;
                iload   = $urandom;
            end
        end
    end

    // One fetch held until the cache delivers it. Entered and left at posedge+1.
    task automatic fetch(input logic [31:0] addr, input int delay);
        int          i;
        logic [31:0] d;
        logic [31:0] al;
        exp_t        e;
        i         = idx_of(addr);
        al        = addr & 32'hFFFF_FFFC;
        mem_delay = delay;
        imemREN   = 1'b1;
        imemaddr  = addr;
        if (m_valid[i] && m_tag[i] == tag_of(addr)) begin
            e.addr = addr;
            e.data = m_data[i];
            hit_q.push_back(e);
            m_hits++;
            @(negedge CLK);
            chk(ihit == 1'b1, "hit_same_cycle", 32'(ihit), 32'd1);
            @(posedge CLK); #1;
        end else begin
            model_miss(addr, d);
            e.addr = addr;
            e.data = d;
            hit_q.push_back(e);
            m_hits++;
            @(negedge CLK);
            chk(ihit == 1'b0, "miss_cycle_ihit", 32'(ihit), 32'd0);
            repeat (delay + 1) begin
                @(posedge CLK); #1;
                @(negedge CLK);
                chk(iREN == 1'b1, "fill_iren", 32'(iREN), 32'd1);
                chk(iaddr == al, "fill_iaddr", iaddr, al);
            end
            @(posedge CLK); #1;
            @(negedge CLK);
            chk(ihit == 1'b1, "refetch_hit", 32'(ihit), 32'd1);
            chk(iREN == 1'b0, "refetch_iren", 32'(iREN), 32'd0);
            @(posedge CLK); #1;
        end
    endtask

    // Miss on addr, then fetch moves elsewhere and drops imemREN mid-fill.
    task automatic redirect(input logic [31:0] addr, input logic [31:0] naddr, input int delay);
        logic [31:0] d;
        logic [31:0] al;
        al        = addr & 32'hFFFF_FFFC;
        mem_delay = delay;
        imemREN   = 1'b1;
        imemaddr  = addr;
        model_miss(addr, d);
        @(negedge CLK);
        chk(ihit == 1'b0, "redir_miss_ihit", 32'(ihit), 32'd0);
        @(posedge CLK); #1;
        imemaddr = naddr;
        imemREN  = 1'b0;
        @(negedge CLK);
        chk(iREN == 1'b1, "redir_iren", 32'(iREN), 32'd1);
        chk(iaddr == al, "redir_iaddr", iaddr, al);
        repeat (delay) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk(iREN == 1'b1, "redir_iren", 32'(iREN), 32'd1);
            chk(iaddr == al, "redir_iaddr", iaddr, al);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        chk(iREN == 1'b0, "redir_done_iren", 32'(iREN), 32'd0);
        @(posedge CLK); #1;
    endtask

    task automatic check_counters(input string nm);
        chk(hit_count == m_hits, {nm, "_hit_count"}, hit_count, m_hits);
        chk(miss_count == m_misses, {nm, "_miss_count"}, miss_count, m_misses);
    endtask

    initial begin
        logic [31:0] m0;
        int          ren0;
        int          r;
        logic [31:0] a;

        mem_ver   = 32'd0;
        mem_delay = 0;
        nRST      = 1'b0;
        imemREN   = 1'b0;
        imemaddr  = 32'h0;
        model_clear();

        // Reset state.
        repeat (2) @(negedge CLK);
        chk(ihit == 1'b0, "rst_ihit", 32'(ihit), 32'd0);
        chk(imemload == 32'h0, "rst_imemload", imemload, 32'h0);
        chk(iREN == 1'b0, "rst_iren", 32'(iREN), 32'd0);
        chk(iaddr == 32'h0, "rst_iaddr", iaddr, 32'h0);
        check_counters("rst");
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Cold miss on 0x40, minimum penalty.
        fetch(32'h0000_0040, 0);
        check_counters("first_miss");

        // 1000 consecutive hits to the warmed address.
        ren0 = ren_cycles;
        m0   = m_misses;
        for (int k = 0; k < 1000; k++) fetch(32'h0000_0040, 0);
        check_counters("hit_run");
        chk(miss_count == m0, "hit_run_misses_unchanged", miss_count, m0);
        chk(ren_cycles == ren0, "hit_run_no_iren", 32'(ren_cycles), 32'(ren0));

        // Async reset in the middle of a fill.
        mem_delay = 5;
        imemREN   = 1'b1;
        imemaddr  = 32'h0000_00C0;
        fill_q.push_back(32'h0000_00C0);
        @(negedge CLK);
        chk(ihit == 1'b0, "rstfill_miss_ihit", 32'(ihit), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk(iREN == 1'b1, "rstfill_iren", 32'(iREN), 32'd1);
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        chk(iREN == 1'b0, "rstfill_async_iren", 32'(iREN), 32'd0);
        chk(iaddr == 32'h0, "rstfill_async_iaddr", iaddr, 32'h0);
        model_clear();
        imemREN = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check_counters("after_rst");
        @(posedge CLK); #1;
        // 0x40 must miss again; iwait held high for three fill cycles.
        fetch(32'h0000_0040, 3);
        check_counters("after_rst_fill");

        // Same-set thrash between 0x04 and 0x44.
        m0 = m_misses;
        mem_ver = 32'd11;
        fetch(32'h0000_0004, 1);
        mem_ver = 32'd12;
        fetch(32'h0000_0044, 0);
        mem_ver = 32'd13;
        fetch(32'h0000_0004, 2);
        chk(miss_count == m0 + 32'd3, "thrash_misses", miss_count, m0 + 32'd3);

        // Redirect during a fill.
        redirect(32'h0000_0080, 32'h0000_0100, 2);
        fetch(32'h0000_0080, 0);
        fetch(32'h0000_0100, 1);
        check_counters("redirect");

        // Randomized traffic over a small address pool so sets collide.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                imemREN  = 1'b0;
                imemaddr = $urandom;
                @(negedge CLK);
                chk(ihit == 1'b0, "idle_no_hit", 32'(ihit), 32'd0);
                @(posedge CLK); #1;
            end else if (r == 1) begin
                mem_ver = mem_ver + 32'd1;
            end else begin
                a = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
                fetch(a, $urandom_range(0, 3));
            end
        end
        imemREN = 1'b0;
        @(negedge CLK);
        check_counters("random");
        chk(hit_q.size() == 0, "hit_q_drained", 32'(hit_q.size()), 32'd0);
        chk(fill_q.size() == 0, "fill_q_drained", 32'(fill_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
